alu32_arbiter: RTL and testbench

// Shares one combinational alu32 between two requesters (req0, req1). Round-robin grant;

---
 rtl/alu32_arbiter.sv | 154 +++++++++++++++
 tb/tb_alu32_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_arbiter.sv
// Round-robin front end that shares one combinational alu32 between two requesters.
// Each accepted operation takes three cycles: IDLE (accept), EXEC (drive ALU), RESP (return result).
`ifndef ALU_AND
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module alu32_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_A,
    input  logic [WIDTH-1:0]  req0_B,
    input  logic [CTRL_W-1:0] req0_control,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_A,
    input  logic [WIDTH-1:0]  req1_B,
    input  logic [CTRL_W-1:0] req1_control,
    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WIDTH-1:0]  res_out,
    output logic              res_overflow,
    output logic              res_zero,
    output logic              res_negative,
    output logic [WIDTH-1:0]  alu_A,
    output logic [WIDTH-1:0]  alu_B,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_out,
    input  logic              alu_overflow,
    input  logic              alu_zero,
    input  logic              alu_negative
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gid_q, gid_d;
    logic [WIDTH-1:0]    op_a_q, op_a_d;
    logic [WIDTH-1:0]    op_b_q, op_b_d;
    logic [CTRL_W-1:0]   op_ctrl_q, op_ctrl_d;
    logic [WIDTH-1:0]    res_out_q, res_out_d;
    logic                res_ovf_q, res_ovf_d;
    logic                res_zero_q, res_zero_d;
    logic                res_neg_q, res_neg_d;
    logic                resp0_valid_q, resp0_valid_d;
    logic                resp1_valid_q, resp1_valid_d;

    logic grant0, grant1, resp_hs;

    // prio names the requester that wins when both are valid in the same cycle
    assign grant0  = (state_q == IDLE) && req0_valid && (!req1_valid || !prio_q);
    assign grant1  = (state_q == IDLE) && req1_valid && (!req0_valid ||  prio_q);
    // Only the granted port's resp_ready matters; the other valid is low in RESP
    assign resp_hs = (resp0_valid_q && resp0_ready) || (resp1_valid_q && resp1_ready);

    always_comb begin
        state_d       = state_q;
        prio_d        = prio_q;
        gid_d         = gid_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        op_ctrl_d     = op_ctrl_q;
        res_out_d     = res_out_q;
        res_ovf_d     = res_ovf_q;
        res_zero_d    = res_zero_q;
        res_neg_d     = res_neg_q;
        resp0_valid_d = resp0_valid_q;
        resp1_valid_d = resp1_valid_q;
        case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    op_a_d    = grant1 ? req1_A       : req0_A;
                    op_b_d    = grant1 ? req1_B       : req0_B;
                    op_ctrl_d = grant1 ? req1_control : req0_control;
                    gid_d     = grant1;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                res_out_d     = alu_out;
                res_ovf_d     = alu_overflow;
                res_zero_d    = alu_zero;
                res_neg_d     = alu_negative;
                resp0_valid_d = !gid_q;
                resp1_valid_d = gid_q;
                state_d       = RESP;
            end
            RESP: begin
                if (resp_hs) begin
                    resp0_valid_d = 1'b0;
                    resp1_valid_d = 1'b0;
                    prio_d        = ~gid_q;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            prio_q        <= 1'b0;
            gid_q         <= 1'b0;
            op_a_q        <= '0;
            op_b_q        <= '0;
            op_ctrl_q     <= '0;
            res_out_q     <= '0;
            res_ovf_q     <= 1'b0;
            res_zero_q    <= 1'b0;
            res_neg_q     <= 1'b0;
            resp0_valid_q <= 1'b0;
            resp1_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            prio_q        <= prio_d;
            gid_q         <= gid_d;
            op_a_q        <= op_a_d;
            op_b_q        <= op_b_d;
            op_ctrl_q     <= op_ctrl_d;
            res_out_q     <= res_out_d;
            res_ovf_q     <= res_ovf_d;
            res_zero_q    <= res_zero_d;
            res_neg_q     <= res_neg_d;
            resp0_valid_q <= resp0_valid_d;
            resp1_valid_q <= resp1_valid_d;
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign resp0_valid  = resp0_valid_q;
    assign resp1_valid  = resp1_valid_q;
    assign res_out      = res_out_q;
    assign res_overflow = res_ovf_q;
    assign res_zero     = res_zero_q;
    assign res_negative = res_neg_q;
    assign alu_A        = op_a_q;
    assign alu_B        = op_b_q;
    assign alu_control  = op_ctrl_q;

endmodule

// File: tb/tb_alu32_arbiter.sv
// Directed bench for alu32_arbiter with a behavioural alu32 attached to the ALU port.
`timescale 1ns/1ps
`ifndef ALU_AND
`define ALU_AND 3'b000
`define ALU_OR  3'b001
`define ALU_ADD 3'b010
`define ALU_XOR 3'b011
`define ALU_NOR 3'b100
`define ALU_SUB 3'b110
`endif

module tb_alu32_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_A = '0, req0_B = '0, req1_A = '0, req1_B = '0;
    logic [2:0]  req0_control = '0, req1_control = '0;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
    logic [31:0] res_out;
    logic        res_overflow, res_zero, res_negative;
    logic [31:0] alu_A, alu_B, alu_out;
    logic [2:0]  alu_control;
    logic        alu_overflow, alu_zero, alu_negative;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu32_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_A(req0_A), .req0_B(req0_B), .req0_control(req0_control),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_A(req1_A), .req1_B(req1_B), .req1_control(req1_control),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .res_out(res_out), .res_overflow(res_overflow),
        .res_zero(res_zero), .res_negative(res_negative),
        .alu_A(alu_A), .alu_B(alu_B), .alu_control(alu_control),
        .alu_out(alu_out), .alu_overflow(alu_overflow),
        .alu_zero(alu_zero), .alu_negative(alu_negative)
    );

    // Behavioural alu32: signed overflow on ADD/SUB only
    always_comb begin
        alu_out      = '0;
        alu_overflow = 1'b0;
        case (alu_control)
            `ALU_ADD: begin
                alu_out      = alu_A + alu_B;
                alu_overflow = (alu_A[31] == alu_B[31]) && (alu_out[31] != alu_A[31]);
            end
            `ALU_SUB: begin
                alu_out      = alu_A - alu_B;
                alu_overflow = (alu_A[31] != alu_B[31]) && (alu_out[31] != alu_A[31]);
            end
            `ALU_AND: alu_out = alu_A & alu_B;
            `ALU_OR:  alu_out = alu_A | alu_B;
            `ALU_NOR: alu_out = ~(alu_A | alu_B);
            `ALU_XOR: alu_out = alu_A ^ alu_B;
            default:  alu_out = '0;
        endcase
        alu_zero     = (alu_out == 32'd0);
        alu_negative = alu_out[31];
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        #2;
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
            begin fails++; $display("FAIL reset_hs: rdy=%b%b rv=%b%b required 0000", req0_ready, req1_ready, resp0_valid, resp1_valid); end
        tests++;
        if (res_out !== 32'd0 || alu_A !== 32'd0 || alu_B !== 32'd0 || alu_control !== 3'd0)
            begin fails++; $display("FAIL reset_data: res=%h aluA=%h aluB=%h ctl=%h required all 0", res_out, alu_A, alu_B, alu_control); end
        reset_n = 1'b1;
        step();
        req0_valid = 1'b1; req0_A = 32'd9; req0_B = 32'd3; req0_control = `ALU_ADD;
        step();
        req0_valid = 1'b0;
        tests++;
        if (alu_A !== 32'd9) begin fails++; $display("FAIL exec_aluA: got %h required 00000009", alu_A); end
        // Reset asserted asynchronously while in EXEC
        reset_n = 1'b0;
        #1;
        tests++;
        if (alu_A !== 32'd0 || alu_B !== 32'd0 || alu_control !== 3'd0 || resp0_valid !== 1'b0 || res_out !== 32'd0)
            begin fails++; $display("FAIL midexec_reset: aluA=%h aluB=%h ctl=%h rv0=%b res=%h required 0", alu_A, alu_B, alu_control, resp0_valid, res_out); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (resp0_valid !== 1'b0 || resp1_valid !== 1'b0)
                begin fails++; $display("FAIL post_reset_resp c%0d: rv=%b%b required 00", i, resp0_valid, resp1_valid); end
        end
        // prio must be 0 after reset: both valid -> req0 wins
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin fails++; $display("FAIL post_reset_prio: rdy=%b%b required 10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        do_reset();
        $display("[TB] test_reset done");
    endtask

    task automatic test_req0_only;
        step();
        req0_valid = 1'b1; req0_A = 32'd8; req0_B = 32'd4; req0_control = `ALU_ADD;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin fails++; $display("FAIL r0_accept: rdy=%b%b required 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0; req0_A = 32'hdead_beef; req0_B = 32'h1234_5678;
        @(negedge clk);
        tests++;
        if (resp0_valid !== 1'b0 || req0_ready !== 1'b0)
            begin fails++; $display("FAIL r0_exec: rv0=%b rdy0=%b required 0 0", resp0_valid, req0_ready); end
        step();
        tests++;
        if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || res_out !== 32'd12 ||
            res_overflow !== 1'b0 || res_zero !== 1'b0 || res_negative !== 1'b0)
            begin fails++; $display("FAIL r0_resp: rv=%b%b res=%h ovz n=%b%b%b required 10 0000000c 000", resp0_valid, resp1_valid, res_out, res_overflow, res_zero, res_negative); end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        tests++;
        if (resp0_valid !== 1'b0) begin fails++; $display("FAIL r0_done: rv0=%b required 0", resp0_valid); end
        $display("[TB] test_req0_only done res=%h", res_out);
    endtask

    task automatic test_req1_only;
        req1_valid = 1'b1; req1_A = 32'd7; req1_B = 32'd7; req1_control = `ALU_SUB;
        @(negedge clk);
        tests++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0)
            begin fails++; $display("FAIL r1_accept: rdy=%b%b required 01", req0_ready, req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        tests++;
        if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || res_out !== 32'd0 ||
            res_zero !== 1'b1 || res_overflow !== 1'b0 || res_negative !== 1'b0)
            begin fails++; $display("FAIL r1_resp: rv=%b%b res=%h ovzn=%b%b%b required 01 00000000 010", resp0_valid, resp1_valid, res_out, res_overflow, res_zero, res_negative); end
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;
        tests++;
        if (resp1_valid !== 1'b0 || resp0_valid !== 1'b0)
            begin fails++; $display("FAIL r1_done: rv=%b%b required 00", resp0_valid, resp1_valid); end
        $display("[TB] test_req1_only done res=%h", res_out);
    endtask

    task automatic test_both_from_reset;
        do_reset();
        req0_valid = 1'b1; req0_A = 32'd2; req0_B = 32'd5; req0_control = `ALU_SUB;
        req1_valid = 1'b1; req1_A = 32'h7fff_ffff; req1_B = 32'd2; req1_control = `ALU_ADD;
        @(negedge clk);
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            begin fails++; $display("FAIL both_first: rdy=%b%b required 10", req0_ready, req1_ready); end
        step();
        req0_valid = 1'b0;
        step();
        tests++;
        if (resp0_valid !== 1'b1 || res_out !== 32'hffff_fffd || res_negative !== 1'b1 ||
            res_overflow !== 1'b0 || res_zero !== 1'b0 || req1_ready !== 1'b0)
            begin fails++; $display("FAIL both_r0: rv0=%b res=%h ovzn=%b%b%b rdy1=%b required 1 fffffffd 001 0", resp0_valid, res_out, res_overflow, res_zero, res_negative, req1_ready); end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        tests++;
        if (req1_ready !== 1'b1) begin fails++; $display("FAIL both_second: rdy1=%b required 1", req1_ready); end
        step();
        req1_valid = 1'b0;
        step();
        tests++;
        if (resp1_valid !== 1'b1 || resp0_valid !== 1'b0 || res_out !== 32'h8000_0001 ||
            res_overflow !== 1'b1 || res_negative !== 1'b1 || res_zero !== 1'b0)
            begin fails++; $display("FAIL both_r1: rv=%b%b res=%h ovzn=%b%b%b required 01 80000001 101", resp0_valid, resp1_valid, res_out, res_overflow, res_zero, res_negative); end
        resp1_ready = 1'b1;
        step();
        resp1_ready = 1'b0;
        $display("[TB] test_both_from_reset done");
    endtask

    task automatic test_backpressure;
        req0_valid = 1'b1; req0_A = 32'd5; req0_B = 32'd6; req0_control = `ALU_ADD;
        step();
        req1_valid = 1'b1; req1_A = 32'd1; req1_B = 32'd1; req1_control = `ALU_ADD;
        resp1_ready = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (resp0_valid !== 1'b1 || resp1_valid !== 1'b0 || res_out !== 32'd11 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                begin fails++; $display("FAIL bp_hold c%0d: rv=%b%b res=%h rdy=%b%b required 10 0000000b 00", i, resp0_valid, resp1_valid, res_out, req0_ready, req1_ready); end
            step();
        end
        resp0_ready = 1'b1;
        step();
        resp0_ready = 1'b0;
        tests++;
        if (resp0_valid !== 1'b0 || req1_ready !== 1'b1 || req0_ready !== 1'b0)
            begin fails++; $display("FAIL bp_release: rv0=%b rdy=%b%b required 0 01", resp0_valid, req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0; resp1_ready = 1'b0;
        $display("[TB] test_backpressure done");
    endtask

    task automatic test_back_to_back;
        logic [2:0]  codes [0:3];
        logic [31:0] exp_res [0:3];
        int acc, rsp, last_acc, g;
        bit acc_seen;
        codes[0] = `ALU_AND; codes[1] = `ALU_OR; codes[2] = `ALU_NOR; codes[3] = `ALU_XOR;
        exp_res[0] = 32'd0; exp_res[1] = 32'd373; exp_res[2] = 32'hffff_fe8a; exp_res[3] = 32'd373;
        do_reset();
        acc = 0; rsp = 0; last_acc = -3;
        req0_A = 32'd17; req0_B = 32'd356; req1_A = 32'd17; req1_B = 32'd356;
        req0_control = codes[0]; req1_control = codes[0];
        req0_valid = 1'b1; req1_valid = 1'b1; resp0_ready = 1'b1; resp1_ready = 1'b1;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            acc_seen = 1'b0;
            if (req0_ready || req1_ready) begin
                g = req1_ready ? 1 : 0;
                tests++;
                if ((req0_ready && req1_ready) || g != acc % 2 || cyc - last_acc != 3)
                    begin fails++; $display("FAIL b2b_grant #%0d: port=%0d gap=%0d required port %0d gap 3", acc, g, cyc - last_acc, acc % 2); end
                last_acc = cyc;
                acc_seen = 1'b1;
            end
            if (resp0_valid || resp1_valid) begin
                g = resp1_valid ? 1 : 0;
                tests++;
                if ((resp0_valid && resp1_valid) || g != rsp % 2 || res_out !== exp_res[rsp % 4])
                    begin fails++; $display("FAIL b2b_resp #%0d: port=%0d res=%h required port %0d res %h", rsp, g, res_out, rsp % 2, exp_res[rsp % 4]); end
                else $display("[TB] b2b op %0d port %0d res=%h", rsp, g, res_out);
                rsp++;
            end
            step();
            if (acc_seen) begin
                acc++;
                req0_control = codes[acc % 4];
                req1_control = codes[acc % 4];
                if (acc == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            end
        end
        tests++;
        if (acc != 6 || rsp != 6)
            begin fails++; $display("FAIL b2b_count: accepts=%0d responses=%0d required 6 6", acc, rsp); end
        resp0_ready = 1'b0; resp1_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_req0_only();
        test_req1_only();
        test_both_from_reset();
        test_backpressure();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
